// File: rtl/lut_neuron_array_pipe_pkg.sv
// Shared defaults and width helper for the LUT neuron array pipeline.
package lut_neuron_array_pipe_pkg;

   localparam int DEF_IN_W   = 8;
   localparam int DEF_OUT_W  = 1;
   localparam int DEF_N_NEUR = 4;

   // Select width for n targets; never narrower than one bit so a
   // single-neuron array still has a real cfg_sel port.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lut_neuron_array_pipe_ram.sv
// One neuron's lookup table: synchronous write, asynchronous read.
// Contents are deliberately not reset so tables survive a pipeline reset.
module lut_neuron_ram
   import lut_neuron_array_pipe_pkg::*;
#(
   parameter int ADDR_W = DEF_IN_W,
   parameter int DATA_W = DEF_OUT_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   (* rom_style = "distributed" *) logic [DATA_W-1:0] mem [2**ADDR_W];

   // Table write; an async read of the same entry on this edge still sees the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_array_pipe.sv
// Array of N_NEUR LUT neurons behind a two-stage valid/ready pipeline.
// S1 captures the input addresses; S2 captures the table lookups.
module lut_neuron_array_pipe
   import lut_neuron_array_pipe_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int N_NEUR = DEF_N_NEUR
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [N_NEUR*IN_W-1:0]        s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [N_NEUR*OUT_W-1:0]       m_data,
   input  logic                          cfg_we,
   input  logic [clog2_min1(N_NEUR)-1:0] cfg_sel,
   input  logic [IN_W-1:0]               cfg_addr,
   input  logic [OUT_W-1:0]              cfg_data,
   output logic [31:0]                   beat_cnt
);

   localparam int SEL_W = clog2_min1(N_NEUR);

   logic                     en;
   logic                     accept;
   logic                     beat_done;
   logic                     s1_valid;
   logic [N_NEUR*IN_W-1:0]   s1_data;
   logic [N_NEUR*OUT_W-1:0]  rd_data;

   // The whole pipe freezes only while the output holds an unaccepted beat.
   // A table write blocks new input so an accepted beat never races its own config.
   assign en        = !(m_valid && !m_ready);
   assign s_ready   = en && !cfg_we;
   assign accept    = s_valid && s_ready;
   assign beat_done = m_valid && m_ready;

   for (genvar n = 0; n < N_NEUR; n++) begin : g_neur
      logic we_n;

      // Out-of-range selects match no neuron and are dropped.
      assign we_n = cfg_we && (cfg_sel == SEL_W'(n));

      lut_neuron_ram #(
         .ADDR_W (IN_W),
         .DATA_W (OUT_W)
      ) u_ram (
         .clk   (clk),
         .we    (we_n),
         .waddr (cfg_addr),
         .wdata (cfg_data),
         .raddr (s1_data[n*IN_W +: IN_W]),
         .rdata (rd_data[n*OUT_W +: OUT_W])
      );
   end

   // S1: capture accepted addresses; an idle input becomes a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= accept;
         if (accept) begin
            s1_data <= s_data;
         end
      end
   end

   // S2: register the table lookups; data only updates on real beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (en) begin
         m_valid <= s1_valid;
         if (s1_valid) begin
            m_data <= rd_data;
         end
      end
   end

   // Delivered-beat counter, free-running wrap at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else begin
         beat_cnt <= beat_cnt + {31'd0, beat_done};
      end
   end

endmodule
